// File: rtl/niosii_system_sysinfo_if.sv
// Avalon-MM slave bus for the system-information block: word-addressed,
// fixed read latency, no waitrequest.
interface niosii_system_sysinfo_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/niosii_system_sysinfo.sv
// System-information Avalon-MM slave: build ID/timestamp, 64-bit cycle counter with
// atomic high-word snapshot, seconds uptime, scratch and freeze/clear control.
module niosii_system_sysinfo #(
    parameter logic [31:0] ID          = 32'h5A5A0001,
    parameter logic [31:0] TIMESTAMP   = 32'd0,
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    // Reset value of the cycle counter; left at 0 except to reach a word carry quickly.
    parameter logic [63:0] CYCLE_RESET = 64'd0
) (
    input logic                     clock,
    input logic                     reset_n,
    niosii_system_sysinfo_if.slave  bus
);

    localparam int unsigned      PW      = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0]    PRE_MAX = PW'(CLK_FREQ_HZ - 1);

    logic [63:0]   cycle_q;
    logic [PW-1:0] pre_q;
    logic [31:0]   uptime_q;
    logic [31:0]   shadow_q;
    logic [31:0]   scratch_q;
    logic          freeze_q;
    logic [31:0]   readdata_q;
    logic          readdatavalid_q;

    logic          rd_en;
    logic          ctrl_wr;
    logic          scratch_wr;
    logic          clear;
    logic [31:0]   rd_mux;

    // A simultaneous write wins; the read is dropped.
    assign rd_en      = bus.read && !bus.write;
    assign ctrl_wr    = bus.write && (bus.address == 3'd6) && bus.byteenable[0];
    assign scratch_wr = bus.write && (bus.address == 3'd5);
    assign clear      = ctrl_wr && bus.writedata[1];

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux = ID;
            3'd1:    rd_mux = TIMESTAMP;
            3'd2:    rd_mux = cycle_q[31:0];
            3'd3:    rd_mux = shadow_q;
            3'd4:    rd_mux = uptime_q;
            3'd5:    rd_mux = scratch_q;
            3'd6:    rd_mux = {31'd0, freeze_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q         <= CYCLE_RESET;
            pre_q           <= '0;
            uptime_q        <= '0;
            shadow_q        <= '0;
            scratch_q       <= '0;
            freeze_q        <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            if (clear) begin
                cycle_q  <= '0;
                pre_q    <= '0;
                uptime_q <= '0;
            end else if (!freeze_q) begin
                cycle_q <= cycle_q + 64'd1;
                if (pre_q == PRE_MAX) begin
                    pre_q    <= '0;
                    uptime_q <= uptime_q + 32'd1;
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end

            if (ctrl_wr) begin
                freeze_q <= bus.writedata[0];
            end

            if (scratch_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.byteenable[i]) begin
                        scratch_q[8*i +: 8] <= bus.writedata[8*i +: 8];
                    end
                end
            end

            readdatavalid_q <= rd_en;
            if (rd_en) begin
                readdata_q <= rd_mux;
                // Snapshot the high word alongside the low word it belongs to.
                if (bus.address == 3'd2) begin
                    shadow_q <= cycle_q[63:32];
                end
            end
        end
    end

    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = readdatavalid_q;

endmodule
